// File: rtl/fu_result_broadcaster.sv
// ============================================================================
// Module : fu_result_broadcaster
// Queues ALU/LS results and drives one registered ROB broadcast per cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

module fu_result_broadcaster #(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_IDX   = 2
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic                     in_flush,
    input  logic                     in_fu_alu_valid,
    input  logic [`ROB_IDX_SIZE-1:0] in_fu_alu_rob_index,
    input  logic [`GPR_SIZE-1:0]     in_fu_alu_value,
    input  logic                     in_fu_alu_set_nzcv,
    input  logic [3:0]               in_fu_alu_nzcv,
    output logic                     out_fu_alu_ready,
    input  logic                     in_fu_ls_valid,
    input  logic [`ROB_IDX_SIZE-1:0] in_fu_ls_rob_index,
    input  logic [`GPR_SIZE-1:0]     in_fu_ls_value,
    output logic                     out_fu_ls_ready,
    output logic                     out_rob_broadcast_done,
    output logic [`ROB_IDX_SIZE-1:0] out_rob_broadcast_index,
    output logic [`GPR_SIZE-1:0]     out_rob_broadcast_value,
    output logic                     out_rob_broadcast_set_nzcv,
    output logic [3:0]               out_rob_broadcast_nzcv
);

    localparam int ENTRY_W = `ROB_IDX_SIZE + `GPR_SIZE + 5;
    localparam int IDX_LSB = `GPR_SIZE + 5;
    localparam logic [FIFO_IDX:0]   C_READY_MAX = (FIFO_IDX + 1)'(FIFO_DEPTH - 2);
    localparam logic [FIFO_IDX:0]   C_CNT_ONE   = (FIFO_IDX + 1)'(1);
    localparam logic [FIFO_IDX-1:0] C_PTR_ONE   = FIFO_IDX'(1);

    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    logic [FIFO_IDX-1:0] r_rd_ptr;
    logic [FIFO_IDX-1:0] r_wr_ptr;
    logic [FIFO_IDX:0]   r_count;

    logic                w_ready;
    logic                w_alu_acc;
    logic                w_ls_acc;
    logic [ENTRY_W-1:0]  w_alu_entry;
    logic [ENTRY_W-1:0]  w_ls_entry;
    logic [ENTRY_W-1:0]  w_out_entry;
    logic                w_out_valid;
    logic                w_pop;
    logic                w_push0_valid;
    logic                w_push1_valid;
    logic [ENTRY_W-1:0]  w_push0;
    logic [ENTRY_W-1:0]  w_push1;
    logic [FIFO_IDX-1:0] w_wr_ptr_p1;
    logic [FIFO_IDX-1:0] w_wr_ptr_next;
    logic [FIFO_IDX-1:0] w_rd_ptr_next;
    logic [FIFO_IDX:0]   w_count_next;

    // Ready depends only on registered occupancy, leaving room for two pushes.
    assign w_ready          = (r_count <= C_READY_MAX);
    assign out_fu_alu_ready = w_ready;
    assign out_fu_ls_ready  = w_ready;

    assign w_alu_acc   = in_fu_alu_valid & w_ready;
    assign w_ls_acc    = in_fu_ls_valid & w_ready;
    assign w_alu_entry = {in_fu_alu_rob_index, in_fu_alu_value, in_fu_alu_set_nzcv, in_fu_alu_nzcv};
    assign w_ls_entry  = {in_fu_ls_rob_index, in_fu_ls_value, 1'b0, 4'b0000};
    assign w_wr_ptr_p1 = r_wr_ptr + C_PTR_ONE;

    // Oldest candidate goes to the output register; the rest enter the queue in order.
    always_comb begin
        w_out_valid   = 1'b0;
        w_out_entry   = w_alu_entry;
        w_pop         = 1'b0;
        w_push0_valid = 1'b0;
        w_push0       = w_alu_entry;
        w_push1_valid = 1'b0;
        w_push1       = w_ls_entry;
        if (r_count != '0) begin
            w_out_valid   = 1'b1;
            w_out_entry   = r_mem[r_rd_ptr];
            w_pop         = 1'b1;
            w_push0_valid = w_alu_acc | w_ls_acc;
            w_push0       = w_alu_acc ? w_alu_entry : w_ls_entry;
            w_push1_valid = w_alu_acc & w_ls_acc;
        end else if (w_alu_acc) begin
            w_out_valid   = 1'b1;
            w_out_entry   = w_alu_entry;
            w_push0_valid = w_ls_acc;
            w_push0       = w_ls_entry;
        end else if (w_ls_acc) begin
            w_out_valid   = 1'b1;
            w_out_entry   = w_ls_entry;
        end
    end

    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        if (w_push1_valid) begin
            w_wr_ptr_next = w_wr_ptr_p1 + C_PTR_ONE;
        end else if (w_push0_valid) begin
            w_wr_ptr_next = w_wr_ptr_p1;
        end
        w_rd_ptr_next = w_pop ? (r_rd_ptr + C_PTR_ONE) : r_rd_ptr;
        w_count_next  = r_count;
        if (w_push0_valid) w_count_next = w_count_next + C_CNT_ONE;
        if (w_push1_valid) w_count_next = w_count_next + C_CNT_ONE;
        if (w_pop)         w_count_next = w_count_next - C_CNT_ONE;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (in_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge in_clk) begin
        if (in_rst_n && !in_flush) begin
            if (w_push0_valid) r_mem[r_wr_ptr]    <= w_push0;
            if (w_push1_valid) r_mem[w_wr_ptr_p1] <= w_push1;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_rob_broadcast_done     <= 1'b0;
            out_rob_broadcast_index    <= '0;
            out_rob_broadcast_value    <= '0;
            out_rob_broadcast_set_nzcv <= 1'b0;
            out_rob_broadcast_nzcv     <= 4'b0000;
        end else if (in_flush) begin
            out_rob_broadcast_done     <= 1'b0;
        end else begin
            out_rob_broadcast_done     <= w_out_valid;
            if (w_out_valid) begin
                {out_rob_broadcast_index, out_rob_broadcast_value,
                 out_rob_broadcast_set_nzcv, out_rob_broadcast_nzcv} <= w_out_entry;
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow_push: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (!in_flush && w_push0_valid) |-> (r_count <= C_READY_MAX));
    a_no_x_alu_index: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (!in_flush && w_alu_acc) |-> !$isunknown(in_fu_alu_rob_index));
    a_no_x_ls_index: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (!in_flush && w_ls_acc) |-> !$isunknown(in_fu_ls_rob_index));
    a_no_x_pop_index: assert property (@(posedge in_clk) disable iff (!in_rst_n)
        (!in_flush && w_pop) |-> !$isunknown(r_mem[r_rd_ptr][ENTRY_W-1:IDX_LSB]));
`endif

endmodule

`default_nettype wire
